// File: rtl/jacobi_sweep_ctrl_if.sv
// Signal bundle between the Jacobi sweep sequencer and its angle unit / rotation engine.
// Handshakes: ang_req is held until the cycle ang_ack is seen; rot_start is a one-cycle pulse answered later by rot_done.
interface jacobi_sweep_ctrl_if #(
    parameter int N       = 4,
    parameter int SWEEP_W = 4
);
    localparam int IW = $clog2(N);

    logic               start;
    logic [SWEEP_W-1:0] num_sweeps;
    logic               busy;
    logic               done;
    logic [IW-1:0]      p_idx;
    logic [IW-1:0]      q_idx;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               ang_req;
    logic               ang_ack;
    logic               rot_start;
    logic               rot_done;
    logic               wb_en;

    modport master (
        output start, num_sweeps, ang_ack, rot_done,
        input  busy, done, p_idx, q_idx, sweep_cnt, ang_req, rot_start, wb_en
    );

    modport slave (
        input  start, num_sweeps, ang_ack, rot_done,
        output busy, done, p_idx, q_idx, sweep_cnt, ang_req, rot_start, wb_en
    );
endinterface

// File: rtl/jacobi_sweep_ctrl.sv
// Jacobi sweep sequencer: walks the row-cyclic (p,q) pair order for a programmed number
// of sweeps, requesting an angle, a row rotation and a write-back for every pair.
module jacobi_sweep_ctrl #(
    parameter int N       = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    jacobi_sweep_ctrl_if.slave bus,
    output logic [2:0]         fsm_state
);
    localparam int IW    = $clog2(N);
    localparam int PAIRS = N * (N - 1) / 2;
    localparam int PCW   = $clog2(PAIRS);
    localparam logic [IW-1:0]  LAST_Q    = IW'(N - 1);
    localparam logic [PCW-1:0] LAST_PAIR = PCW'(PAIRS - 1);

    typedef enum logic [2:0] {IDLE, ANGLE, ROT, WAIT, WB, FIN} state_t;

    state_t             state;
    state_t             state_nx;
    logic [IW-1:0]      p_r;
    logic [IW-1:0]      q_r;
    logic [PCW-1:0]     pair_r;
    logic [SWEEP_W-1:0] sweep_r;
    logic [SWEEP_W-1:0] target_r;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               sweep_end;

    assign sweep_end = (pair_r == LAST_PAIR);
    assign sweep_inc = sweep_r + 1'b1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.num_sweeps != '0) ? ANGLE : FIN;
            ANGLE:   if (bus.ang_ack) state_nx = ROT;
            ROT:     state_nx = WAIT;
            WAIT:    if (bus.rot_done) state_nx = WB;
            WB:      state_nx = (sweep_end && (sweep_inc == target_r)) ? FIN : ANGLE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            p_r      <= '0;
            q_r      <= IW'(1);
            pair_r   <= '0;
            sweep_r  <= '0;
            target_r <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                target_r <= bus.num_sweeps;
                p_r      <= '0;
                q_r      <= IW'(1);
                pair_r   <= '0;
                sweep_r  <= '0;
            end else if (state == WB) begin
                // Pair indices only move here, so they stay put from ANGLE through WB.
                if (sweep_end) begin
                    p_r     <= '0;
                    q_r     <= IW'(1);
                    pair_r  <= '0;
                    sweep_r <= sweep_inc;
                end else begin
                    pair_r <= pair_r + 1'b1;
                    if (q_r == LAST_Q) begin
                        p_r <= p_r + 1'b1;
                        q_r <= p_r + IW'(2);
                    end else begin
                        q_r <= q_r + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.ang_req   = (state == ANGLE);
    assign bus.rot_start = (state == ROT);
    assign bus.wb_en     = (state == WB);
    assign bus.p_idx     = p_r;
    assign bus.q_idx     = q_r;
    assign bus.sweep_cnt = sweep_r;
    assign fsm_state     = state;
endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// Bench for jacobi_sweep_ctrl: expected (sweep,p,q) triples queued at launch and popped on rot_start.
module tb_jacobi_sweep_ctrl;
    localparam int N       = 4;
    localparam int SWEEP_W = 4;
    localparam int IW      = $clog2(N);
    localparam int W       = SWEEP_W + 2 * IW;
    localparam int PAIRS   = N * (N - 1) / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fsm_state;

    jacobi_sweep_ctrl_if #(.N(N), .SWEEP_W(SWEEP_W)) bus();

    jacobi_sweep_ctrl #(.N(N), .SWEEP_W(SWEEP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    logic [W-1:0] obs;
    bit active   = 0;
    bit ack_tied = 0;
    bit spur     = 0;
    bit in_pair  = 0;
    int ack_delay, rd_delay, t0, exp_done, exp_sweeps, exp_ang_len;
    int rot_cnt, wb_cnt, ang_cnt, done_cnt, busy_cnt, ang_run, wait_run;
    int done_any = 0;

    always @(negedge clk) begin
        if (bus.done) done_any++;
        if (active) begin
            obs = {bus.sweep_cnt, bus.p_idx, bus.q_idx};
            if (bus.busy) busy_cnt++;
            if (bus.ang_req) begin
                ang_cnt++;
                ang_run++;
                if (exp_q.size() > 0) check_eq("pair_in_angle", obs, exp_q[0]);
                else check_eq("angle_unexpected", exp_q.size(), 1);
            end
            if (bus.rot_start) begin
                rot_cnt++;
                check_eq("ang_req_len", ang_run, exp_ang_len);
                ang_run = 0;
                if (exp_q.size() > 0) begin
                    cur_exp = exp_q.pop_front();
                    check_eq("rot_pair", obs, cur_exp);
                end else begin
                    check_eq("rot_unexpected", exp_q.size(), 1);
                end
                in_pair  = 1;
                wait_run = 0;
            end else if (bus.wb_en) begin
                wb_cnt++;
                check_eq("wb_pair", obs, cur_exp);
                check_eq("wait_len", wait_run, rd_delay);
                in_pair = 0;
            end else if (in_pair) begin
                wait_run++;
                check_eq("pair_in_wait", obs, cur_exp);
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("done_cycle", cyc - t0, exp_done);
                check_eq("sweep_at_done", bus.sweep_cnt, exp_sweeps);
                check_eq("pairs_left", exp_q.size(), 0);
            end
        end
    end

    // ---------------- responders: angle unit and rotation engine ----------------
    int acnt  = 0;
    int rd_cnt = 0;
    bit rd_fire;

    always @(negedge clk) begin
        if (!rst_n) begin
            acnt         = 0;
            rd_cnt       = 0;
            bus.ang_ack  = 1'b0;
            bus.rot_done = 1'b0;
        end else begin
            if (bus.ang_req) acnt++;
            else acnt = 0;
            bus.ang_ack = ack_tied || (bus.ang_req && (acnt > ack_delay));
            rd_fire = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) rd_fire = 1;
            end
            if (bus.rot_start) rd_cnt = rd_delay;
            bus.rot_done = rd_fire || (spur && (bus.ang_req || bus.rot_start));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input int ns, input bit tied, input int ad, input int rd, input bit sp);
        ack_tied  = tied;
        ack_delay = ad;
        rd_delay  = rd;
        spur      = sp;
        exp_q.delete();
        for (int s = 0; s < ns; s++)
            for (int p = 0; p < N - 1; p++)
                for (int q = p + 1; q < N; q++)
                    exp_q.push_back({SWEEP_W'(s), IW'(p), IW'(q)});
        exp_ang_len = tied ? 1 : ad + 1;
        exp_done    = 1 + ns * PAIRS * (exp_ang_len + rd + 2);
        exp_sweeps  = ns;
        rot_cnt = 0; wb_cnt = 0; ang_cnt = 0; done_cnt = 0; busy_cnt = 0;
        ang_run = 0; wait_run = 0; in_pair = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_sweeps = SWEEP_W'(ns);
        t0             = cyc;
        active         = 1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.num_sweeps = SWEEP_W'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int ns);
        bit prev_rot = 0;
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk);
            k++;
            bus.start = spur && prev_rot;
            prev_rot  = bus.rot_start;
        end
        bus.start = 1'b0;
        check_eq("done_timeout", done_cnt > 0, 1);
        repeat (3) @(negedge clk);
        check_eq("done_count", done_cnt, 1);
        check_eq("rot_count", rot_cnt, ns * PAIRS);
        check_eq("wb_count", wb_cnt, ns * PAIRS);
        check_eq("ang_count", ang_cnt, ns * PAIRS * exp_ang_len);
        check_eq("busy_cycles", busy_cnt, exp_done);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("hold_sweep", bus.sweep_cnt, ns);
        check_eq("hold_pair", {bus.p_idx, bus.q_idx}, {IW'(0), IW'(1)});
        active = 0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_ang_req"}, bus.ang_req, 0);
        check_eq({tag, "_rot_start"}, bus.rot_start, 0);
        check_eq({tag, "_wb_en"}, bus.wb_en, 0);
        check_eq({tag, "_p"}, bus.p_idx, 0);
        check_eq({tag, "_q"}, bus.q_idx, 1);
        check_eq({tag, "_sweep"}, bus.sweep_cnt, 0);
        check_eq({tag, "_state"}, fsm_state, 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        bit found;
        int k;
        int done_base;
        bus.start      = 1'b0;
        bus.num_sweeps = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        launch(1, 1, 0, 1, 0); wait_done(1);   // single sweep
        launch(2, 1, 0, 1, 0); wait_done(2);   // two sweeps, pair wrap
        launch(0, 1, 0, 1, 0); wait_done(0);   // zero sweeps
        launch(1, 0, 3, 5, 0); wait_done(1);   // stalled ack and rot_done
        launch(1, 1, 0, 1, 1); wait_done(1);   // spurious start / rot_done

        // abort in WAIT of pair (1,2)
        launch(2, 1, 0, 1, 0);
        found = 0;
        k = 0;
        while (!found && k < 500) begin
            @(negedge clk);
            k++;
            found = bus.rot_start && (bus.p_idx == IW'(1)) && (bus.q_idx == IW'(2));
        end
        check_eq("abort_pair_found", found, 1);
        @(negedge clk);
        active    = 0;
        done_base = done_any;
        rst_n     = 1'b0;
        #1;
        check_reset("abort");
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", done_any, done_base);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_idle_busy", bus.busy, 0);
        launch(1, 1, 0, 1, 0); wait_done(1);   // restarts at (0,1)

        for (int i = 0; i < 3; i++) begin
            int ns;
            ns = $urandom_range(1, 3);
            launch(ns, 0, $urandom_range(0, 2), $urandom_range(1, 3), 0);
            wait_done(ns);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jacobi_sweep_ctrl.md
JACOBI_SWEEP_CTRL -- requirements
Module: jacobi_sweep_ctrl

Interface
REQ-001 Parameter N, default 4: matrix dimension; legal values are 3 to 16.
REQ-002 Parameter SWEEP_W, default 4: width of the sweep-count input.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. The clock port is clk and the reset port is rst_n.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run; sampled only in IDLE.
- num_sweeps  in  SWEEP_W  sweep count; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all sweeps are complete.
- p_idx  out  clog2(N)  current row p.
- q_idx  out  clog2(N)  current row q.
- sweep_cnt  out  SWEEP_W  number of completed sweeps.
- ang_req  out  1  requests the angle unit to compute sin/cos for (p_idx, q_idx).
- ang_ack  in  1  angle unit reports sin/cos valid.
- rot_start  out  1  one-cycle start pulse to the row-rotation engine.
- rot_done  in  1  rotation engine reports both new rows written.
- wb_en  out  1  one-cycle write-back strobe for the new p and q rows.

Function
REQ-005 The FSM SHALL have the states IDLE, ANGLE, ROT, WAIT, WB, FIN.
REQ-006 In IDLE, start=1 SHALL capture num_sweeps, clear p_idx, sweep_cnt and the internal pair counter, and set q_idx=1.
REQ-007 Transition out of IDLE on accepted start:
- num_sweeps!=0: go to ANGLE.
- num_sweeps==0: go to FIN with no rot_start issued.
REQ-008 ANGLE: ang_req=1. On ang_ack=1, go to ROT in the next cycle; otherwise stay in ANGLE.
REQ-009 ROT: rot_start=1 for exactly one cycle, then go to WAIT.
REQ-010 WAIT: on rot_done=1, go to WB; otherwise stay in WAIT indefinitely (no timeout).
REQ-011 WB: wb_en=1 for exactly one cycle, then advance the pair per REQ-012.
REQ-012 Pair order is row-cyclic: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), giving N(N-1)/2 pairs per sweep.
- If q<N-1: q=q+1.
- Otherwise: p=p+1 and q=p+2.
- After (N-2,N-1): wrap to (0,1) and increment sweep_cnt.
REQ-013 After a WB, go to FIN if the incremented sweep_cnt equals the captured num_sweeps; otherwise go to ANGLE.
REQ-014 FIN: done=1 for one cycle, then go to IDLE. sweep_cnt, p_idx and q_idx SHALL hold their values in IDLE until the next accepted start.
REQ-015 p_idx and q_idx SHALL be stable from entry to ANGLE through the end of WB.
REQ-016 Inputs are ignored outside their own states:
- start is ignored when not in IDLE.
- ang_ack is ignored when not in ANGLE.
- rot_done is ignored when not in WAIT, including a rot_done coincident with rot_start.
REQ-017 A change on num_sweeps while busy SHALL have no effect.
REQ-018 All outputs SHALL be registered (Moore): ang_req, rot_start, wb_en, busy and done decode the registered state only.
REQ-019 Per-pair latency with ang_ack held high and rot_done arriving one cycle after rot_start SHALL be 4 cycles (ANGLE, ROT, WAIT, WB).

Reset
REQ-020 When rst_n=0, asynchronously:
- state=IDLE.
- busy=0, done=0, ang_req=0, rot_start=0, wb_en=0.
- p_idx=0, q_idx=1, sweep_cnt=0, captured sweep count=0.
REQ-021 Reset asserted mid-sweep SHALL abort with no done pulse. After reset release the block waits for a new start.

Verification
REQ-022 Single sweep: N=4, num_sweeps=1, ang_ack tied 1, rot_done one cycle after each rot_start, start at cycle 0.
- Required: 6 rot_start pulses at pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- Required: 6 wb_en pulses.
- Required: done at cycle 25, busy high for cycles 1-25, sweep_cnt=1.
REQ-023 Two sweeps: num_sweeps=2.
- Required: 12 rot_start pulses, with the pair wrapping to (0,1) after (2,3).
- Required: sweep_cnt=1 during the second sweep and sweep_cnt=2 at done.
REQ-024 Zero sweeps: num_sweeps=0.
- Required: done at cycle 1.
- Required: no ang_req, rot_start or wb_en pulse.
REQ-025 Stalls: ang_ack delayed 3 cycles and rot_done delayed 5 cycles.
- Required: ang_req held high for 4 cycles and WAIT lasts 5 cycles.
- Required: exactly one rot_start per pair, with p_idx and q_idx stable throughout.
REQ-026 Spurious inputs: start pulsed in WAIT, and rot_done pulsed in ANGLE.
- Required: both ignored, with sequence and counts identical to REQ-022.
REQ-027 Reset in WAIT of pair (1,2).
- Required: all outputs match REQ-020 immediately, with no done pulse.
- Required: a new start restarts at (0,1).
